spi_storage_arbiter: RTL and testbench



---
 rtl/spi_arb_pkg.sv | 35 +++
 rtl/spi_storage_arbiter_sck_gen.sv | 55 +++++
 rtl/spi_storage_arbiter.sv | 148 ++++++++++++++
 tb/tb_spi_storage_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types, default timing constants and width helpers for the SPI storage arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam int unsigned DEF_NUM_CH    = 3;
  localparam int unsigned DEF_SEL_W     = 2;
  localparam int unsigned DEF_DIV_W     = 8;
  localparam int unsigned DEF_SETUP_CYC = 1;
  localparam int unsigned DEF_HOLD_CYC  = 1;
  localparam int unsigned DEF_GAP_CYC   = 1;

  // Smallest owner_sel width able to address n channels (at least 1 bit).
  function automatic int unsigned min_sel_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  // Counter width able to hold values 0 .. max_cnt-1 (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < max_cnt) w++;
    return w;
  endfunction

endpackage

// File: rtl/spi_storage_arbiter_sck_gen.sv
// Mode-0 SCK generator: divided clock as a registered level plus edge strobes.
module spi_sck_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic             stop_req,
  output logic             sck,
  output logic             rise,
  output logic             fall,
  output logic             at_low
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_sck;
  logic             r_rise;
  logic             r_fall;
  logic             w_toggle;

  assign w_toggle = (r_cnt == div);
  // Safe to stop: SCK is low now, or the scheduled fall happens at this edge.
  assign at_low   = !r_sck || w_toggle;

  assign sck  = r_sck;
  assign rise = r_rise;
  assign fall = r_fall;

  // Half-period counter; a pending rise is suppressed once a stop is requested.
  always_ff @(posedge clk) begin
    if (!rstn || !run) begin
      r_cnt  <= '0;
      r_sck  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_toggle) begin
        r_cnt <= '0;
        if (r_sck) begin
          r_sck  <= 1'b0;
          r_fall <= 1'b1;
        end else if (!stop_req) begin
          r_sck  <= 1'b1;
          r_rise <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_storage_arbiter.sv
// Owner-selected arbiter sharing one SPI storage link; FSM sequences SCS setup/hold/gap.
module spi_storage_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned SEL_W     = DEF_SEL_W,
  parameter int unsigned DIV_W     = DEF_DIV_W,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
  parameter int unsigned GAP_CYC   = DEF_GAP_CYC
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [SEL_W-1:0]  owner_sel,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              spi_sck,
  output logic              spi_scs,
  output logic [NUM_CH-1:0] grant,
  output logic              busy,
  output logic              sck_rise,
  output logic              sck_fall
);

  localparam int unsigned MAX_CYC_SH = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned MAX_CYC    = (MAX_CYC_SH > GAP_CYC) ? MAX_CYC_SH : GAP_CYC;
  localparam int unsigned CNT_W      = cnt_width(MAX_CYC);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [NUM_CH-1:0] r_grant;
  logic              r_busy;
  logic              r_scs;

  logic [NUM_CH-1:0] w_sel_oh;
  logic              w_req;
  logic              w_own_en;
  logic              w_run;
  logic              w_at_low;
  logic              w_sck;
  logic              w_rise;
  logic              w_fall;

  // Decode owner_sel to one-hot; out-of-range selects decode to no owner.
  always_comb begin
    w_sel_oh = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (owner_sel == SEL_W'(i)) w_sel_oh[i] = 1'b1;
    end
  end

  assign w_req    = |(w_sel_oh & ch_en);
  // The latched grant doubles as the owner index, so only its enable is watched.
  assign w_own_en = |(r_grant & ch_en);
  assign w_run    = (r_state == ST_ACTIVE);

  spi_sck_gen #(
    .DIV_W(DIV_W)
  ) u_sck_gen (
    .clk      (clk),
    .rstn     (rstn),
    .run      (w_run),
    .div      (r_div),
    .stop_req (!w_own_en),
    .sck      (w_sck),
    .rise     (w_rise),
    .fall     (w_fall),
    .at_low   (w_at_low)
  );

  assign spi_sck  = w_sck;
  assign sck_rise = w_rise;
  assign sck_fall = w_fall;
  assign spi_scs  = r_scs;
  assign grant    = r_grant;
  assign busy     = r_busy;

  // Transfer sequencing with registered SCS, grant and busy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_scs   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state <= ST_SETUP;
            r_cnt   <= '0;
            r_div   <= clk_div;
            r_grant <= w_sel_oh;
            r_busy  <= 1'b1;
            r_scs   <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_state <= ST_ACTIVE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!w_own_en && w_at_low) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
          end
        end
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
            r_grant <= '0;
            r_scs   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_scs   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_storage_arbiter.sv
// Self-checking bench: per-cycle comparison against an event-timeline model of each transfer.
module tb_spi_storage_arbiter;
  import spi_arb_pkg::*;

  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned SEL_W     = min_sel_w(NUM_CH);
  localparam int unsigned DIV_W     = 8;
  localparam int unsigned SETUP_CYC = 2;
  localparam int unsigned HOLD_CYC  = 2;
  localparam int unsigned GAP_CYC   = 1;

  logic              clk;
  logic              rstn;
  logic [SEL_W-1:0]  owner_sel;
  logic [NUM_CH-1:0] ch_en;
  logic [DIV_W-1:0]  clk_div;
  logic              spi_sck;
  logic              spi_scs;
  logic [NUM_CH-1:0] grant;
  logic              busy;
  logic              sck_rise;
  logic              sck_fall;

  int n_checks;
  int n_errors;

  spi_storage_arbiter #(
    .NUM_CH    (NUM_CH),
    .SEL_W     (SEL_W),
    .DIV_W     (DIV_W),
    .SETUP_CYC (SETUP_CYC),
    .HOLD_CYC  (HOLD_CYC),
    .GAP_CYC   (GAP_CYC)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .owner_sel (owner_sel),
    .ch_en     (ch_en),
    .clk_div   (clk_div),
    .spi_sck   (spi_sck),
    .spi_scs   (spi_scs),
    .grant     (grant),
    .busy      (busy),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".scs"},   32'(spi_scs),  32'(1));
    check({tag, ".sck"},   32'(spi_sck),  32'(0));
    check({tag, ".grant"}, 32'(grant),    32'(0));
    check({tag, ".busy"},  32'(busy),     32'(0));
    check({tag, ".rise"},  32'(sck_rise), 32'(0));
    check({tag, ".fall"},  32'(sck_fall), 32'(0));
  endtask

  // SCK level after edge t, following the uninterrupted schedule of a transfer
  // whose ACTIVE phase begins at edge a with half period d+1.
  function automatic logic high_after(input int t, input int a, input int d);
    if (t < a) return 1'b0;
    return ((t - a) % (2 * (d + 1))) >= (d + 1);
  endfunction

  // First edge leaving ACTIVE: at or after the enable drop is sampled and after
  // ACTIVE starts, never in the middle of a high phase.
  function automatic int exit_edge(input int a, input int d, input int drop_k);
    int t;
    t = (drop_k > a + 1) ? drop_k : a + 1;
    while (high_after(t - 1, a, d) && high_after(t, a, d)) t++;
    return t;
  endfunction

  function automatic logic sck_model(input int t, input int a, input int x, input int d);
    if (t < 0) return 1'b0;
    return (t >= a && t < x) ? high_after(t, a, d) : 1'b0;
  endfunction

  // One whole transfer, edge 0 being the IDLE edge that takes the request and
  // drop_k the first edge at which the owner's enable is sampled low.
  task automatic run_xfer(input int owner, input int d, input int drop_k,
                          input int sel_busy, input logic [NUM_CH-1:0] oth, input bit rnd);
    int a, x, last;
    logic [NUM_CH-1:0] oh;
    logic cs, ps;
    a    = SETUP_CYC;
    x    = exit_edge(a, d, drop_k);
    last = x + HOLD_CYC + GAP_CYC;
    oh   = NUM_CH'(1) << owner;
    owner_sel = SEL_W'(owner);
    clk_div   = DIV_W'(d);
    ch_en     = oth | oh;
    for (int t = 0; t <= last; t++) begin
      step();
      cs = sck_model(t, a, x, d);
      ps = sck_model(t - 1, a, x, d);
      check("xfer.scs",   32'(spi_scs),  32'(!(t < x + HOLD_CYC)));
      check("xfer.grant", 32'(grant),    32'((t < x + HOLD_CYC) ? oh : '0));
      check("xfer.busy",  32'(busy),     32'(t < last));
      check("xfer.sck",   32'(spi_sck),  32'(cs));
      check("xfer.rise",  32'(sck_rise), 32'(cs && !ps));
      check("xfer.fall",  32'(sck_fall), 32'(!cs && ps));
      if (rnd) begin
        owner_sel = SEL_W'($urandom);
        clk_div   = DIV_W'($urandom);
        ch_en     = NUM_CH'($urandom);
      end else begin
        owner_sel = SEL_W'(sel_busy);
        ch_en     = oth;
      end
      ch_en[owner] = (t + 1 < drop_k);
    end
  endtask

  initial begin
    int ow, dv, dk;
    n_checks  = 0;
    n_errors  = 0;
    rstn      = 1'b0;
    owner_sel = '0;
    ch_en     = '0;
    clk_div   = '0;

    step();
    step();
    check_idle("reset");
    rstn = 1'b1;
    step();
    check_idle("post_reset");

    // Stop while SCK high: enable dropped one cycle after the first rise.
    run_xfer(1, 1, 5, 1, 3'b000, 1'b0);
    // Stop while SCK low, mid low phase.
    run_xfer(1, 2, 9, 1, 3'b000, 1'b0);
    // Enable dropped during SETUP: no SCK pulse at all.
    run_xfer(2, 1, 1, 2, 3'b000, 1'b0);
    // Owner switch 1 -> 0 mid-transfer with ch_en=3'b011, then channel 0 takes over.
    run_xfer(1, 1, 7, 0, 3'b001, 1'b0);
    run_xfer(0, 0, 6, 0, 3'b001, 1'b0);

    // Out-of-range owner never starts a transfer.
    owner_sel = SEL_W'(3);
    ch_en     = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("invalid_owner");
    end

    // Randomised transfers; owner_sel/clk_div/other enables churn while busy.
    for (int n = 0; n < 30; n++) begin
      ow = int'($urandom_range(NUM_CH - 1, 0));
      dv = int'($urandom_range(3, 0));
      dk = int'($urandom_range(SETUP_CYC + 8 * (dv + 1), 1));
      run_xfer(ow, dv, dk, 0, '0, 1'b1);
    end

    // Reset in the middle of a high SCK phase.
    owner_sel = SEL_W'(2);
    ch_en     = 3'b100;
    clk_div   = DIV_W'(1);
    for (int i = 0; i < 5; i++) step();
    check("midrst.pre_sck", 32'(spi_sck), 32'(1));
    rstn  = 1'b0;
    ch_en = '0;
    step();
    check_idle("midrst");
    rstn = 1'b1;
    step();
    check_idle("midrst_after");

    // Normal operation resumes after the reset.
    run_xfer(0, 0, 4, 0, 3'b000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
